// File: rtl/memory_stage.sv
// RV32I memory stage: lane-formats loads/stores onto a req/gnt/rvalid data bus and stalls the pipe while an access is outstanding.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module memory_stage #(
  parameter  int unsigned ADDR_WIDTH     = 32,
  parameter  int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned DATA_WIDTH     = 32,
  localparam int unsigned BE_WIDTH       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_valid_i,
  input  logic                  MEM_MemRead_i,
  input  logic                  MEM_MemWrite_i,
  input  logic [2:0]            MEM_funct3_i,
  input  logic [31:0]           MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_rs2_data_i,
  output logic [DATA_WIDTH-1:0] MEM_read_data_o,
  output logic                  MEM_stall_o,
  output logic                  MEM_misaligned_o,
  output logic                  MEM_bus_err_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [BE_WIDTH-1:0]   dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic                  is_byte;
  logic                  is_half;
  logic                  is_word;
  logic                  mem_op;
  logic                  addr_misaligned;
  logic                  start;
  logic                  timeout;
  logic [BE_WIDTH-1:0]   be_fmt;
  logic [DATA_WIDTH-1:0] wdata_fmt;
  logic [2:0]            funct3_reg;
  logic [1:0]            offset_reg;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_fmt;

  // Access size decode; unlisted funct3 encodings behave as word accesses.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    case (MEM_funct3_i)
      3'b000, 3'b100: is_byte = 1'b1;
      3'b001, 3'b101: is_half = 1'b1;
      default: ;
    endcase
  end
  assign is_word = !is_byte && !is_half;

  assign mem_op          = MEM_valid_i && (MEM_MemRead_i || MEM_MemWrite_i);
  assign addr_misaligned = (is_word && (MEM_alu_result_i[1:0] != 2'b00)) ||
                           (is_half && MEM_alu_result_i[0]);
  assign start            = (state == IDLE) && mem_op && !addr_misaligned;
  assign MEM_misaligned_o = (state == IDLE) && mem_op && addr_misaligned;

  // Store lane placement; loads request the full word.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = '0;
    if (MEM_MemWrite_i) begin
      wdata_fmt = MEM_rs2_data_i;
      if (is_byte) begin
        be_fmt    = 4'b0001 << MEM_alu_result_i[1:0];
        wdata_fmt = {4{MEM_rs2_data_i[7:0]}};
      end else if (is_half) begin
        be_fmt    = MEM_alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{MEM_rs2_data_i[15:0]}};
      end
    end
  end

  // Lane extraction and extension of the returned word.
  always_comb begin
    load_byte = dmem_rdata_i[{offset_reg, 3'b000} +: 8];
    load_half = dmem_rdata_i[{offset_reg[1], 4'b0000} +: 16];
    case (funct3_reg)
      3'b000:  load_fmt = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_fmt = {24'b0, load_byte};
      3'b001:  load_fmt = {{16{load_half[15]}}, load_half};
      3'b101:  load_fmt = {16'b0, load_half};
      default: load_fmt = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_next  = state;
    MEM_stall_o = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = REQ;
          MEM_stall_o = 1'b1;
        end
      end
      REQ: begin
        MEM_stall_o = 1'b1;
        if (dmem_gnt_i)   state_next = dmem_we_o ? DONE : WAIT;
        else if (timeout) state_next = DONE;
      end
      WAIT: begin
        MEM_stall_o = 1'b1;
        if (dmem_rvalid_i || timeout) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      dmem_req_o      <= 1'b0;
      dmem_we_o       <= 1'b0;
      dmem_addr_o     <= '0;
      dmem_be_o       <= '0;
      dmem_wdata_o    <= '0;
      funct3_reg      <= '0;
      offset_reg      <= '0;
      MEM_read_data_o <= '0;
    end else begin
      state      <= state_next;
      dmem_req_o <= (state_next == REQ);
      if (start) begin
        dmem_we_o    <= MEM_MemWrite_i;
        dmem_addr_o  <= ADDR_WIDTH'({MEM_alu_result_i[31:2], 2'b00});
        dmem_be_o    <= be_fmt;
        dmem_wdata_o <= wdata_fmt;
        funct3_reg   <= MEM_funct3_i;
        offset_reg   <= MEM_alu_result_i[1:0];
      end
      // An abandoned load returns zero rather than stale data.
      if (state == WAIT && dmem_rvalid_i) MEM_read_data_o <= load_fmt;
      else if (timeout && !dmem_we_o)     MEM_read_data_o <= '0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;
  logic       bus_err;

  assign timeout = (wait_cnt == TIMEOUT_LIMIT) &&
                   ((state == REQ && !dmem_gnt_i) || (state == WAIT && !dmem_rvalid_i));

  // Counts cycles spent in REQ and WAIT since the access began.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (start)                              wait_cnt <= '0;
      else if (state == REQ || state == WAIT) wait_cnt <= wait_cnt + 8'd1;
      bus_err <= timeout;
    end
  end

  assign MEM_bus_err_o = bus_err;
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign MEM_bus_err_o      = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the RISC-V pipeline, directly downstream of `execute_stage`. It takes the EX ALU result as an effective address and performs RV32I loads and stores on a single-port data bus with a req/gnt/rvalid handshake. Store data is lane-aligned with byte enables, and load data is lane-extracted with sign or zero extension. The pipeline is stalled while a bus access is outstanding.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, data bus address width.
- `TIMEOUT_CYCLES`, 16, watchdog limit in cycles. Used only with `MEM_TIMEOUT_EN`; legal range 2..255.

Ports (`DATA_WIDTH` = 32 from `defines`):
- `clk` in 1: single clock. All state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `MEM_valid_i` in 1: an instruction is present in MEM.
- `MEM_MemRead_i` in 1: the instruction is a load.
- `MEM_MemWrite_i` in 1: the instruction is a store. Never high together with `MemRead`.
- `MEM_funct3_i` in 3: width/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU. Any other value is treated as W.
- `MEM_alu_result_i` in 32: effective byte address.
- `MEM_rs2_data_i` in 32: store data.
- `MEM_read_data_o` out 32: extended load data.
- `MEM_stall_o` out 1: hold all upstream stages.
- `MEM_misaligned_o` out 1: misaligned access flag. Combinational.
- `MEM_bus_err_o` out 1: watchdog timeout flag.
- `dmem_req_o` out 1: bus request.
- `dmem_we_o` out 1: request is a write.
- `dmem_addr_o` out `ADDR_WIDTH`: word-aligned address, bits [1:0] = 00.
- `dmem_be_o` out 4: byte enables.
- `dmem_wdata_o` out 32: lane-replicated write data.
- `dmem_gnt_i` in 1: request accepted.
- `dmem_rvalid_i` in 1: read data valid.
- `dmem_rdata_i` in 32: read word.

## Operation
The stage has four states: IDLE, REQ, WAIT, DONE.

A memory op is started when all of these hold: `MEM_valid_i`, (`MemRead` or `MemWrite`), and not misaligned.

Misaligned is defined as:
- W access with `addr[1:0] != 0`, or
- H/HU access with `addr[0] != 0`.

State behaviour:
- **IDLE, started op:**
  - Assert `MEM_stall_o` combinationally.
  - At the clock edge, register:
    - `addr[31:2]`;
    - read/write;
    - `funct3`;
    - `addr[1:0]`;
    - `be`;
    - `wdata`.
  - Go to REQ.
- **IDLE, misaligned op:** no bus activity and no stall. `MEM_misaligned_o` = 1 in the same cycle. `MEM_read_data_o` is unchanged.
- **IDLE, non-memory op or `MEM_valid_i` = 0:** pass through with no stall.
- **REQ:** `dmem_req_o` = 1 with stable registered `addr`/`we`/`be`/`wdata`.
  - `gnt` on a write goes to DONE.
  - `gnt` on a read goes to WAIT.
  - Without `gnt`, stay in REQ.
- **WAIT:** on `rvalid`, register the formatted data into `MEM_read_data_o` and go to DONE.
- **DONE:** stall = 0, the pipeline advances this cycle. Inputs are ignored because the same instruction is still presented. Next state is IDLE.

`MEM_stall_o` = (IDLE and started) or REQ or WAIT.

Store lane formatting:
- **SB:** `be = 0001 << addr[1:0]`; `wdata = {4{rs2[7:0]}}`.
- **SH:** `be = addr[1] ? 1100 : 0011`; `wdata = {2{rs2[15:0]}}`.
- **SW:** `be = 1111`; `wdata = rs2`.

Reads drive `be = 1111`.

Load formatting:
- Select byte `addr[1:0]` or halfword `addr[1]` of `rdata`.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

## Timing
Reset values:
- State = IDLE.
- `MEM_read_data_o` = 0.
- `dmem_req_o` = 0, `dmem_we_o` = 0, `dmem_addr_o` = 0, `dmem_be_o` = 0, `dmem_wdata_o` = 0.
- `MEM_bus_err_o` = 0.
- Stall is 0 when idle.

Latency, counting the start cycle as cycle 0:
- Store with immediate `gnt` (cycle 1): DONE at cycle 2, so 3 cycles total.
- Load with `gnt` at cycle 1 and `rvalid` at cycle 2: DONE at cycle 3, data visible at cycle 3.

Handshake rules:
- `req` and all payload stay stable from REQ entry until `gnt` is sampled.
- `req` deasserts in the cycle after `gnt`.
- `gnt` and `rvalid` are ignored outside REQ and WAIT respectively.
- An `rvalid` arriving in the same cycle as `gnt` is not legal; the bus guarantees `rvalid` at least 1 cycle after `gnt`.

Reset mid-operation: in the cycle after `rst` the state is IDLE and `req` = 0. A late `rvalid` is discarded and `MEM_read_data_o` stays 0.

`MEM_read_data_o` holds its value until the next load completion.

## Configuration
Macro `MEM_TIMEOUT_EN`:
- **Defined:**
  - An 8-bit counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - On reaching `TIMEOUT_CYCLES` without the awaited `gnt`/`rvalid`:
    - go to DONE;
    - drop `req`;
    - a load gets `MEM_read_data_o` = 0.
  - `MEM_bus_err_o` = 1 for the DONE cycle only.
- **Not defined:** no counter. The stage waits indefinitely and `MEM_bus_err_o` is tied to 0.

## Test plan
- **SW:** addr 0x100, rs2 0xDEADBEEF, `gnt` at once. Expect:
  - `req` for 1 cycle with `addr` 0x100, `be` 1111, `wdata` 0xDEADBEEF, `we` = 1;
  - stall for 2 cycles, then DONE.
- **SB:** addr 0x103, rs2 0x000000A5. Expect `be` 1000, `wdata` 0xA5A5A5A5, `addr` 0x100.
- **LB / LBU:** addr 0x102, `rdata` 0x00800000, `gnt` delayed 3 cycles, `rvalid` 2 cycles later. Expect:
  - LB result 0xFFFFFF80; LBU result 0x00000080;
  - stall held throughout;
  - `req` payload stable until `gnt`.
- **LH at addr 0x101:**
  - Expect `MEM_misaligned_o` = 1, no `req`, no stall, read data unchanged.
- **Reset asserted while in WAIT**, then `rvalid` with `rdata` 0x12345678. Expect:
  - IDLE;
  - `MEM_read_data_o` = 0;
  - the next instruction is accepted normally.
- **With `MEM_TIMEOUT_EN`:** `TIMEOUT_CYCLES` = 16, `gnt` never asserted. Expect:
  - after 16 REQ cycles, DONE with `MEM_bus_err_o` = 1 for 1 cycle;
  - `req` low;
  - load data 0.
